ring_slot_scheduler: RTL and testbench
======================================

// Module: ring_slot_scheduler
// PURPOSE
//  Round-robin time-slot arbiter built around an N-position one-hot ring token.
//  Shares one downstream resource among N requesters. Owner of token slot i may hold grant i until release.
//  Sits between requester blocks and the shared datapath; gnt drives the datapath's select/enable.
// PARAMETERS
//  N           6   number of requesters / ring positions (>=2)
//  MAX_HOLD    8   max consecutive grant cycles before forced revoke; 0 = no limit
//  SKIP_EMPTY  1   1: token jumps to next requesting slot; 0: token steps one slot per cycle
// PORTS
//  clk      in   1   single clock; all state updates on rising edge
//  clr      in   1   asynchronous, active-high reset
//  en       in   1   arbitration enable; 0 = no new grants and token frozen in IDLE
//  req      in   N   request per slot, level; held until served
//  rel      in   N   release per slot; only rel[granted slot] is sampled
//  gnt      out  N   grant, registered; all-zero or one-hot
//  token    out  N   current ring position, one-hot
//  busy     out  1   1 while a grant is held (state HOLD)
//  timeout  out  1   one-cycle pulse when a grant is force-revoked at MAX_HOLD
// BEHAVIOUR
//  Reset (async, immediate, also mid-grant): token=1 (slot 0), gnt=0, busy=0, timeout=0, cnt=0, state=IDLE.
//  States: IDLE -> HOLD -> GAP -> IDLE.
//  - IDLE, en=1, SKIP_EMPTY=1: pick the first req bit at or after token, scanning circularly toward the MSB.
//    Next edge: gnt=token=that slot, cnt=1, busy=1, go to HOLD. Latency req->gnt = 1 cycle.
//  - IDLE, en=1, SKIP_EMPTY=0: if req[token] is set, grant as above.
//    Otherwise rotate the token left by one (slot N-1 -> slot 0) each cycle.
//  - IDLE, en=0 or req=0 (SKIP_EMPTY=1): hold all state; token does not move.
//  - HOLD (g = granted slot): end the grant when rel[g]=1, or req[g]=0, or (MAX_HOLD!=0 and cnt==MAX_HOLD).
//    Otherwise cnt++ and gnt is held. en=0 does not revoke a held grant.
//  - End of grant, next edge: gnt=0, busy=0, token=rotl(token) (one past g, for fairness), state=GAP.
//    timeout=1 for that one cycle only when the end was caused by cnt reaching MAX_HOLD.
//  - Simultaneous rel[g] and cnt==MAX_HOLD: release wins; timeout stays 0.
//  - GAP: one dead cycle, timeout returns to 0, go to IDLE.
//    Back-to-back grants are therefore separated by 1 idle cycle: gnt period >= hold+1.
//  - rel on non-granted slots and req changes during HOLD are ignored. A new req on slot g after the end of its grant waits its turn.
//  - Wrap: the circular scan and the rotate wrap from slot N-1 to slot 0.
//    Example, N=6: token=6'b100000, req=6'b000010 -> grant slot 1.
//  - Invariants: token always one-hot; gnt!=0 implies gnt==token.
//    Self-correction: if token is ever not one-hot, it is reloaded to 1 on the next edge.
//  - cnt width: $clog2(MAX_HOLD+1), minimum 1. cnt saturates; it never wraps.
// STRUCTURE
//  Shared package ring_sched_pkg holds:
//    - state encodings (IDLE=2'd0, HOLD=2'd1, GAP=2'd2)
//    - function rotl1(vec) for the one-hot rotate
//    - function first_from(req, token) for the circular priority pick
//  One sub-module, ring_token: N-bit one-hot register with async clr to 1, a rotate enable,
//    a parallel load, and the one-hot self-correction.
//  FSM, hold counter and output regs live in ring_slot_scheduler.
// TESTING
//  1. Reset: assert clr mid-HOLD (gnt=6'b000100) -> same cycle gnt=0, token=6'b000001, busy=0.
//  2. Single request: en=1, req=6'b001000 -> next edge gnt=6'b001000, busy=1.
//     Then rel[3]=1 -> next edge gnt=0, token=6'b010000, then GAP.
//  3. Round robin: req=6'b111111 held, each grantee releases after 2 cycles.
//     -> grants go slot 0,1,2,3,4,5,0; each gnt lasts 2 cycles followed by 1 idle cycle.
//  4. Wrap: token=6'b100000 (after slot 4 served), req=6'b000011 -> gnt=6'b000001.
//  5. Timeout: MAX_HOLD=8, req[2] held, no rel -> gnt[2] high 8 cycles, then timeout=1 for exactly 1 cycle.
//     Repeat with rel[2] asserted on cycle 8 -> timeout stays 0.
//  6. SKIP_EMPTY=0 and en gating: req=6'b010000, token at 0 -> token steps 1 per cycle, gnt after 5 cycles.
//     Drop en mid-scan -> token freezes. Drop en during HOLD -> grant kept.

Source files
------------

// File: rtl/ring_sched_pkg.sv
// rtl/ring_sched_pkg.sv - shared state encoding and one-hot ring helpers for the slot scheduler
package ring_sched_pkg;

  localparam int MAX_N = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef logic [MAX_N-1:0] vec_t;

  function automatic vec_t ring_mask(input int n);
    return (vec_t'(1) << n) - vec_t'(1);
  endfunction

  // Bits at or above n are expected to be zero on entry.
  function automatic vec_t rotl1(input vec_t vec, input int n);
    return ((vec << 1) | (vec >> (n - 1))) & ring_mask(n);
  endfunction

  function automatic vec_t first_from(input vec_t req, input vec_t token, input int n);
    vec_t cand;
    vec_t pick;
    logic found;
    cand  = token;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n && !found && (cand & req) != '0) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = rotl1(cand, n);
    end
    return pick;
  endfunction

endpackage

// File: rtl/ring_slot_scheduler_if.sv
// rtl/ring_slot_scheduler_if.sv - requester-side bundle of the ring slot scheduler
interface ring_slot_scheduler_if #(
  parameter int N = 6
);
  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] rel;
  logic [N-1:0] gnt;
  logic [N-1:0] token;
  logic         busy;
  logic         timeout;

  modport master (output en, req, rel, input gnt, token, busy, timeout);
  modport slave  (input en, req, rel, output gnt, token, busy, timeout);
endinterface

// File: rtl/ring_token.sv
// rtl/ring_token.sv - one-hot ring position register with rotate, load and self-correction
module ring_token
  import ring_sched_pkg::*;
#(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         rot,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q
);

  logic [N-1:0] rot_val;

  assign rot_val = N'(rotl1(vec_t'(q), N));

  // A corrupted (non one-hot) ring is reloaded to slot 0 ahead of any other update.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= N'(1);
    end else if (!$onehot(q)) begin
      q <= N'(1);
    end else if (load) begin
      q <= load_val;
    end else if (rot) begin
      q <= rot_val;
    end
  end

endmodule

// File: rtl/ring_slot_scheduler.sv
// rtl/ring_slot_scheduler.sv - round-robin time-slot arbiter around a one-hot ring token
module ring_slot_scheduler
  import ring_sched_pkg::*;
#(
  parameter int N          = 6,
  parameter int MAX_HOLD   = 8,
  parameter int SKIP_EMPTY = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  ring_slot_scheduler_if.slave  bus
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_SAT   = '1;

  state_t        state, state_nxt;
  logic [N-1:0]  gnt_q, gnt_nxt;
  logic          busy_q, busy_nxt;
  logic          to_q, to_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          tok_load, tok_rot;
  logic [N-1:0]  tok, pick;
  logic          can_grant, rel_hit, req_lost, at_limit;

  ring_token #(.N(N)) u_token (
    .clk      (clk),
    .clr      (clr),
    .rot      (tok_rot),
    .load     (tok_load),
    .load_val (pick),
    .q        (tok)
  );

  assign pick = (SKIP_EMPTY != 0) ? N'(first_from(vec_t'(bus.req), vec_t'(tok), N)) : tok;
  assign can_grant = bus.en &&
                     ((SKIP_EMPTY != 0) ? (bus.req != '0) : ((bus.req & tok) != '0));
  assign rel_hit  = (bus.rel & gnt_q) != '0;
  assign req_lost = (bus.req & gnt_q) == '0;
  assign at_limit = (MAX_HOLD != 0) && (cnt == CNT_LIMIT);

  // GAP is the dead cycle; arbitration runs at its closing edge so grants are one cycle apart.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    busy_nxt  = busy_q;
    to_nxt    = 1'b0;
    cnt_nxt   = cnt;
    tok_load  = 1'b0;
    tok_rot   = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (can_grant) begin
          state_nxt = HOLD;
          gnt_nxt   = pick;
          busy_nxt  = 1'b1;
          cnt_nxt   = CW'(1);
          tok_load  = 1'b1;
        end else begin
          state_nxt = IDLE;
          tok_rot   = bus.en && (SKIP_EMPTY == 0);
        end
      end
      HOLD: begin
        if (rel_hit || req_lost || at_limit) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
          tok_rot   = 1'b1;
          to_nxt    = at_limit && !rel_hit && !req_lost;
        end else if (cnt != CNT_SAT) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      gnt_q  <= '0;
      busy_q <= 1'b0;
      to_q   <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      gnt_q  <= gnt_nxt;
      busy_q <= busy_nxt;
      to_q   <= to_nxt;
      cnt    <= cnt_nxt;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.token   = tok;
  assign bus.busy    = busy_q;
  assign bus.timeout = to_q;

endmodule

// File: tb/tb_ring_slot_scheduler.sv
// tb/tb_ring_slot_scheduler.sv - directed self-checking bench for ring_slot_scheduler
module tb_ring_slot_scheduler;

  logic clk = 1'b0;
  logic clr;

  ring_slot_scheduler_if #(.N(6)) ifa ();
  ring_slot_scheduler_if #(.N(6)) ifb ();

  ring_slot_scheduler #(.N(6), .MAX_HOLD(8), .SKIP_EMPTY(1)) dut_a (
    .clk (clk),
    .clr (clr),
    .bus (ifa)
  );

  ring_slot_scheduler #(.N(6), .MAX_HOLD(8), .SKIP_EMPTY(0)) dut_b (
    .clk (clk),
    .clr (clr),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int e;
    int s;
    clr = 1'b1;
    ifa.en = 1'b0; ifa.req = '0; ifa.rel = '0;
    ifb.en = 1'b0; ifb.req = '0; ifb.rel = '0;
    #12;
    check("rst_gnt",     32'(ifa.gnt),     'h00);
    check("rst_token",   32'(ifa.token),   'h01);
    check("rst_busy",    32'(ifa.busy),    'h0);
    check("rst_timeout", 32'(ifa.timeout), 'h0);
    step();
    clr = 1'b0;

    // single request and release
    ifa.en = 1'b1; ifa.req = 6'b001000;
    step();
    check("single_gnt",   32'(ifa.gnt),   'h08);
    check("single_busy",  32'(ifa.busy),  'h1);
    check("single_token", 32'(ifa.token), 'h08);
    ifa.rel = 6'b001000;
    step();
    check("single_rel_gnt",   32'(ifa.gnt),   'h00);
    check("single_rel_token", 32'(ifa.token), 'h10);
    check("single_rel_busy",  32'(ifa.busy),  'h0);
    ifa.rel = '0; ifa.req = '0;
    step();
    check("gap_gnt", 32'(ifa.gnt), 'h00);

    // async reset in the middle of a grant
    ifa.req = 6'b000100;
    step();
    check("pre_clr_gnt", 32'(ifa.gnt), 'h04);
    #2 clr = 1'b1;
    #1;
    check("clr_gnt",   32'(ifa.gnt),   'h00);
    check("clr_token", 32'(ifa.token), 'h01);
    check("clr_busy",  32'(ifa.busy),  'h0);
    step();
    clr = 1'b0; ifa.req = '0;

    // round robin, every slot requesting, each grant released on its 2nd cycle
    ifa.req = 6'b111111;
    for (int i = 0; i < 7; i++) begin
      s = i % 6;
      e = 1 << s;
      step();
      check("rr_gnt_c1", 32'(ifa.gnt), e);
      check("rr_busy",   32'(ifa.busy), 'h1);
      step();
      check("rr_gnt_c2", 32'(ifa.gnt), e);
      ifa.rel = 6'(e);
      step();
      check("rr_gnt_off", 32'(ifa.gnt),   'h00);
      check("rr_token",   32'(ifa.token), 1 << ((s + 1) % 6));
      ifa.rel = '0;
    end

    // serve slot 4 so the token sits at slot 5, then wrap to slot 0
    ifa.req = 6'b010000;
    step();
    check("s4_gnt", 32'(ifa.gnt), 'h10);
    ifa.rel = 6'b010000;
    step();
    check("s4_token", 32'(ifa.token), 'h20);
    ifa.rel = '0; ifa.req = 6'b000011;
    step();
    check("wrap_gnt",   32'(ifa.gnt),   'h01);
    check("wrap_token", 32'(ifa.token), 'h01);
    ifa.rel = 6'b000001;
    step();
    check("wrap_rel_gnt", 32'(ifa.gnt), 'h00);

    // forced revoke after MAX_HOLD cycles
    ifa.rel = '0; ifa.req = 6'b000100;
    step();
    check("to_gnt_c1", 32'(ifa.gnt), 'h04);
    for (int k = 0; k < 7; k++) begin
      step();
      check("to_gnt_hold", 32'(ifa.gnt),     'h04);
      check("to_no_pulse", 32'(ifa.timeout), 'h0);
    end
    step();
    check("to_gnt_off", 32'(ifa.gnt),     'h00);
    check("to_pulse",   32'(ifa.timeout), 'h1);
    check("to_busy",    32'(ifa.busy),    'h0);
    step();
    check("to_pulse_end", 32'(ifa.timeout), 'h0);
    check("to_regrant",   32'(ifa.gnt),     'h04);
    for (int k = 0; k < 7; k++) begin
      step();
      check("rw_gnt_hold", 32'(ifa.gnt), 'h04);
    end
    ifa.rel = 6'b000100;
    step();
    check("rw_gnt_off",  32'(ifa.gnt),     'h00);
    check("rw_no_pulse", 32'(ifa.timeout), 'h0);
    ifa.rel = '0; ifa.req = '0;
    step();
    check("rw_gap_pulse", 32'(ifa.timeout), 'h0);

    // SKIP_EMPTY=0: token steps one slot per enabled cycle
    check("b_token_frozen", 32'(ifb.token), 'h01);
    ifb.en = 1'b1; ifb.req = 6'b010000;
    step();
    check("b_step1", 32'(ifb.token), 'h02);
    step();
    check("b_step2", 32'(ifb.token), 'h04);
    ifb.en = 1'b0;
    step();
    check("b_freeze1", 32'(ifb.token), 'h04);
    step();
    check("b_freeze2", 32'(ifb.token), 'h04);
    check("b_freeze_gnt", 32'(ifb.gnt), 'h00);
    ifb.en = 1'b1;
    step();
    check("b_step3", 32'(ifb.token), 'h08);
    check("b_step3_gnt", 32'(ifb.gnt), 'h00);
    step();
    check("b_step4", 32'(ifb.token), 'h10);
    check("b_step4_gnt", 32'(ifb.gnt), 'h00);
    step();
    check("b_gnt",  32'(ifb.gnt),  'h10);
    check("b_busy", 32'(ifb.busy), 'h1);
    ifb.en = 1'b0;
    step();
    check("b_hold_en0_1", 32'(ifb.gnt), 'h10);
    step();
    check("b_hold_en0_2", 32'(ifb.gnt), 'h10);
    ifb.rel = 6'b010000;
    step();
    check("b_rel_gnt",   32'(ifb.gnt),   'h00);
    check("b_rel_token", 32'(ifb.token), 'h20);
    check("b_rel_busy",  32'(ifb.busy),  'h0);
    ifb.rel = '0; ifb.req = '0;
    step();
    check("b_idle_gnt",   32'(ifb.gnt),   'h00);
    check("b_idle_token", 32'(ifb.token), 'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
